// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller: FSM encoding, BCD digit
// width and a constant helper used to size score registers.
package pong_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_PLAY      = 3'd2,
        ST_POINT     = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit saturating BCD score counter with a binary shadow copy used for
// arithmetic comparisons elsewhere.
module bcd_counter
    import pong_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      inc,
    output logic [DIGITS*BCD_W-1:0]   bcd,
    output logic [BIN_W-1:0]          bin
);

    logic [DIGITS*BCD_W-1:0] r_bcd;
    logic [DIGITS*BCD_W-1:0] w_bcd_next;
    logic [BIN_W-1:0]        r_bin;
    logic [DIGITS-1:0]       w_nine;
    logic [DIGITS-1:0]       w_carry;
    logic                    w_step;

    // An all-nines score is saturated: the step is suppressed entirely so
    // neither the BCD digits nor the binary shadow move.
    assign w_step = inc & ~(&w_nine);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_nine[gi] = (r_bcd[gi*BCD_W +: BCD_W] == BCD_W'(9));
            if (gi == 0) begin : g_lsd
                assign w_carry[gi] = w_step;
            end else begin : g_upper
                assign w_carry[gi] = w_carry[gi-1] & w_nine[gi-1];
            end
            assign w_bcd_next[gi*BCD_W +: BCD_W] =
                !w_carry[gi] ? r_bcd[gi*BCD_W +: BCD_W] :
                w_nine[gi]   ? '0 :
                               r_bcd[gi*BCD_W +: BCD_W] + BCD_W'(1);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_bcd <= '0;
            r_bin <= '0;
        end else if (w_step) begin
            r_bcd <= w_bcd_next;
            r_bin <= r_bin + BIN_W'(1);
        end
    end

    assign bcd = r_bcd;
    assign bin = r_bin;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve delay, point intake, BCD scoring per player and
// win detection with a configurable minimum lead.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int SCORE_DIGITS = 2,
    parameter int WIN_SCORE    = 11,
    parameter int WIN_MARGIN   = 2,
    parameter int SERVE_DELAY  = 25000000,
    parameter int PW           = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  pause,
    input  logic                                  start,
    input  logic                                  point_valid,
    input  logic [PW-1:0]                         point_player,
    output logic [NUM_PLAYERS*SCORE_DIGITS*4-1:0] score_bcd,
    output logic                                  ball_reset,
    output logic                                  ball_enable,
    output logic [PW-1:0]                         serve_to,
    output logic [PW-1:0]                         winner,
    output logic                                  winner_valid,
    output logic [2:0]                            state
);

    localparam int SW    = SCORE_DIGITS * BCD_W;
    localparam int BIN_W = $clog2(pow10(SCORE_DIGITS));
    localparam int CW    = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_DELAY - 1);
    localparam logic [PW:0]   NP_LIMIT   = (PW+1)'(NUM_PLAYERS);

    state_t              r_state;
    logic                r_start_d;
    logic [CW-1:0]       r_serve_cnt;
    logic                r_ball_reset;
    logic                r_ball_enable;
    logic [PW-1:0]       r_serve_to;
    logic [PW-1:0]       r_winner;
    logic                r_winner_valid;
    logic [PW-1:0]       r_scorer;

    logic                   w_start_rise;
    logic                   w_point_ok;
    logic                   w_clr;
    logic                   w_win;
    logic [NUM_PLAYERS-1:0] w_inc;
    logic [NUM_PLAYERS-1:0] w_beats;
    logic [BIN_W-1:0]       w_bin [NUM_PLAYERS];
    logic [BIN_W-1:0]       w_scorer_bin;

    assign w_start_rise = start & ~r_start_d;
    assign w_point_ok   = (r_state == ST_PLAY) & point_valid & ~pause &
                          ({1'b0, point_player} < NP_LIMIT);
    assign w_clr        = w_start_rise &
                          ((r_state == ST_IDLE) || (r_state == ST_GAME_OVER));

    always_comb begin
        w_scorer_bin = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (r_scorer == PW'(i)) begin
                w_scorer_bin = w_bin[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
            assign w_inc[gi] = w_point_ok && (point_player == PW'(gi));
            // Lead test is done in 32-bit signed space so a trailing scorer
            // can never appear to lead through unsigned wrap.
            assign w_beats[gi] = (r_scorer == PW'(gi)) ||
                                 (int'(w_scorer_bin) >= int'(w_bin[gi]) + WIN_MARGIN);

            bcd_counter #(
                .DIGITS (SCORE_DIGITS),
                .BIN_W  (BIN_W)
            ) u_score (
                .clk   (clk),
                .reset (reset),
                .clr   (w_clr),
                .inc   (w_inc[gi]),
                .bcd   (score_bcd[gi*SW +: SW]),
                .bin   (w_bin[gi])
            );
        end
    endgenerate

    assign w_win = (int'(w_scorer_bin) >= WIN_SCORE) && (&w_beats);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_start_d      <= 1'b1;
            r_serve_cnt    <= '0;
            r_ball_reset   <= 1'b0;
            r_ball_enable  <= 1'b0;
            r_serve_to     <= '0;
            r_winner       <= '0;
            r_winner_valid <= 1'b0;
            r_scorer       <= '0;
        end else begin
            r_start_d     <= start;
            r_ball_reset  <= 1'b0;
            r_ball_enable <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_rise) begin
                        r_state      <= ST_SERVE;
                        r_serve_cnt  <= SERVE_LOAD;
                        r_serve_to   <= '0;
                        r_ball_reset <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (!pause) begin
                        if (r_serve_cnt == '0) begin
                            r_state       <= ST_PLAY;
                            r_ball_enable <= 1'b1;
                        end else begin
                            r_serve_cnt <= r_serve_cnt - CW'(1);
                        end
                    end
                end
                ST_PLAY: begin
                    if (w_point_ok) begin
                        r_state  <= ST_POINT;
                        r_scorer <= point_player;
                    end else begin
                        r_ball_enable <= ~pause;
                    end
                end
                ST_POINT: begin
                    if (w_win) begin
                        r_state        <= ST_GAME_OVER;
                        r_winner       <= r_scorer;
                        r_winner_valid <= 1'b1;
                    end else begin
                        r_state      <= ST_SERVE;
                        r_serve_cnt  <= SERVE_LOAD;
                        r_serve_to   <= r_scorer;
                        r_ball_reset <= 1'b1;
                    end
                end
                ST_GAME_OVER: begin
                    if (w_start_rise) begin
                        r_state        <= ST_SERVE;
                        r_serve_cnt    <= SERVE_LOAD;
                        r_serve_to     <= '0;
                        r_winner_valid <= 1'b0;
                        r_ball_reset   <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ball_reset   = r_ball_reset;
    assign ball_enable  = r_ball_enable;
    assign serve_to     = r_serve_to;
    assign winner       = r_winner;
    assign winner_valid = r_winner_valid;
    assign state        = r_state;

endmodule
